// File: rtl/sched_pkg.sv
// Shared types and helpers for the daily activity sequencer.
// Phase encodings double as the status code driven to the datapath.
package sched_pkg;

    typedef enum logic [1:0] {
        SLEEP   = 2'b00,
        CLASS   = 2'b01,
        STUDY   = 2'b10,
        MEETING = 2'b11
    } phase_e;

    localparam int DWELL_RST = 1;

    function automatic phase_e next_phase(phase_e p);
        phase_e n;
        case (p)
            SLEEP:   n = CLASS;
            CLASS:   n = STUDY;
            STUDY:   n = MEETING;
            default: n = SLEEP;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/day_scheduler_if.sv
// Control/status bundle between the scheduler and its host.
// master drives schedule controls; slave is the scheduler itself.
interface day_scheduler_if #(
    parameter int CNT_W = 8,
    parameter int DAY_W = 8
) ();
    logic             hold;
    logic             cfg_we;
    logic [1:0]       cfg_sel;
    logic [CNT_W-1:0] cfg_data;
    logic             mtg_req;
    logic             mtg_ack;
    logic [1:0]       status;
    logic             home;
    logic [DAY_W-1:0] day_cnt;

    modport master (
        output hold, cfg_we, cfg_sel, cfg_data, mtg_req,
        input  mtg_ack, status, home, day_cnt
    );

    modport slave (
        input  hold, cfg_we, cfg_sel, cfg_data, mtg_req,
        output mtg_ack, status, home, day_cnt
    );
endinterface

// File: rtl/dwell_timer.sv
// Phase dwell counter with clear/enable and terminal compare.
// A zero limit behaves as a one-cycle dwell.
module dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             done_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] eff;

    assign eff    = (limit_i == '0) ? CNT_W'(1) : limit_i;
    // >= so that a dwell shrunk below the elapsed time ends at once
    assign done_o = (cnt_q >= eff - CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/day_scheduler.sv
// Four-phase daily sequencer with meeting preemption and hold.
// All outputs come straight from flops.
module day_scheduler
    import sched_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int DAY_W = 8
) (
    input logic           clk,
    input logic           rst,
    day_scheduler_if.slave bus
);
    phase_e           phase_q, phase_d;
    logic [DAY_W-1:0] day_q, day_d;
    logic             ack_q, ack_d;
    logic             home_q;
    logic [CNT_W-1:0] dwell_q [4];
    logic             clr, en, done;

    dwell_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .en_i    (en),
        .limit_i (dwell_q[phase_q]),
        .done_o  (done)
    );

    // Preemption outranks timeout; both share the ack rule
    always_comb begin
        phase_d = phase_q;
        day_d   = day_q;
        ack_d   = 1'b0;
        clr     = 1'b0;
        en      = 1'b0;
        if (!bus.hold) begin
            en = 1'b1;
            if (phase_q == STUDY && bus.mtg_req) begin
                phase_d = MEETING;
                clr     = 1'b1;
                ack_d   = 1'b1;
            end else if (done) begin
                phase_d = next_phase(phase_q);
                clr     = 1'b1;
                if (phase_q == MEETING)
                    day_d = day_q + DAY_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= SLEEP;
            day_q   <= '0;
            ack_q   <= 1'b0;
            home_q  <= 1'b1;
        end else begin
            phase_q <= phase_d;
            day_q   <= day_d;
            ack_q   <= ack_d;
            home_q  <= (phase_d == SLEEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++)
                dwell_q[i] <= CNT_W'(DWELL_RST);
        end else if (bus.cfg_we) begin
            dwell_q[bus.cfg_sel] <= bus.cfg_data;
        end
    end

    assign bus.status  = phase_q;
    assign bus.home    = home_q;
    assign bus.mtg_ack = ack_q;
    assign bus.day_cnt = day_q;
endmodule

// File: tb/tb_day_scheduler.sv
// Directed bench for day_scheduler: schedule order, dwell,
// preemption, hold, dwell shrink, day wrap and mid-run reset.
module tb_day_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    day_scheduler_if #(.CNT_W(8), .DAY_W(8)) m ();
    day_scheduler_if #(.CNT_W(8), .DAY_W(2)) s ();

    day_scheduler #(.CNT_W(8), .DAY_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m)
    );

    day_scheduler #(.CNT_W(8), .DAY_W(2)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (s)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(string tag, logic [1:0] p);
        int n = 0;
        while (m.status !== p && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(m.status), 32'(p));
    endtask

    task automatic cfg(logic [1:0] sel, logic [7:0] val);
        m.cfg_we   = 1'b1;
        m.cfg_sel  = sel;
        m.cfg_data = val;
        tick();
        m.cfg_we   = 1'b0;
    endtask

    task automatic run_seq(string tag, logic [1:0] q[$]);
        foreach (q[i]) begin
            tick();
            chk($sformatf("%s[%0d]", tag, i), 32'(m.status), 32'(q[i]));
            chk($sformatf("%s_home[%0d]", tag, i), 32'(m.home),
                32'(q[i] == 2'b00));
        end
    endtask

    logic [1:0] seq_a[$] = '{0, 0, 1, 1, 2, 2, 2, 2, 2, 3, 0};
    logic [1:0] seq_b[$] = '{0, 0, 1, 2, 2, 2, 2, 2, 3, 0};

    initial begin
        m.hold = 0; m.cfg_we = 0; m.cfg_sel = 0;
        m.cfg_data = 0; m.mtg_req = 0;
        s.hold = 0; s.cfg_we = 0; s.cfg_sel = 0;
        s.cfg_data = 0; s.mtg_req = 0;
        tick();
        tick();
        chk("rst_status", 32'(m.status), 0);
        chk("rst_home", 32'(m.home), 1);
        chk("rst_ack", 32'(m.mtg_ack), 0);
        chk("rst_day", 32'(m.day_cnt), 0);

        // default dwell: one phase per cycle, day every 4
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("def_st%0d", i), 32'(m.status), 32'(i % 4));
            chk($sformatf("def_home%0d", i), 32'(m.home),
                32'(i % 4 == 0));
            chk($sformatf("def_ack%0d", i), 32'(m.mtg_ack), 0);
            if (i % 4 == 0) begin
                chk($sformatf("def_day%0d", i), 32'(m.day_cnt), 32'(i / 4));
                chk($sformatf("wrap_day%0d", i), 32'(s.day_cnt),
                    32'((i / 4) % 4));
            end
        end

        // program {3,2,5,1} under hold
        m.hold = 1'b1;
        cfg(2'd0, 8'd3);
        cfg(2'd1, 8'd2);
        cfg(2'd2, 8'd5);
        cfg(2'd3, 8'd1);
        chk("hold_cfg_st", 32'(m.status), 0);
        chk("hold_cfg_day", 32'(m.day_cnt), 4);
        m.hold = 1'b0;
        run_seq("dw", seq_a);
        chk("dw_day", 32'(m.day_cnt), 5);

        // zero dwell on CLASS acts as one cycle
        m.hold = 1'b1;
        cfg(2'd1, 8'd0);
        m.hold = 1'b0;
        run_seq("dw0", seq_b);
        chk("dw0_day", 32'(m.day_cnt), 6);

        // request during CLASS only is ignored
        wait_phase("to_class", 2'd1);
        m.mtg_req = 1'b1;
        tick();
        m.mtg_req = 1'b0;
        chk("creq_st", 32'(m.status), 2);
        chk("creq_ack", 32'(m.mtg_ack), 0);

        // preempt STUDY at timer 2 of 5
        tick();
        tick();
        chk("pre_st_study", 32'(m.status), 2);
        m.mtg_req = 1'b1;
        tick();
        chk("pre_st", 32'(m.status), 3);
        chk("pre_ack", 32'(m.mtg_ack), 1);
        m.mtg_req = 1'b0;
        tick();
        chk("pre_after_st", 32'(m.status), 0);
        chk("pre_after_ack", 32'(m.mtg_ack), 0);
        chk("pre_day", 32'(m.day_cnt), 7);

        // hold without request freezes the timer
        wait_phase("to_study1", 2'd2);
        tick();
        m.hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("hz_st%0d", i), 32'(m.status), 2);
        end
        m.hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hz_rel%0d", i), 32'(m.status), 2);
        end
        tick();
        chk("hz_mtg", 32'(m.status), 3);
        chk("hz_ack", 32'(m.mtg_ack), 0);

        // hold with request pending
        wait_phase("to_study2", 2'd2);
        tick();
        m.hold = 1'b1;
        m.mtg_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("hr_st%0d", i), 32'(m.status), 2);
            chk($sformatf("hr_ack%0d", i), 32'(m.mtg_ack), 0);
        end
        m.hold = 1'b0;
        tick();
        chk("hr_st", 32'(m.status), 3);
        chk("hr_ack", 32'(m.mtg_ack), 1);
        chk("hr_home", 32'(m.home), 0);
        m.mtg_req = 1'b0;

        // shrink STUDY dwell from 10 to 2 at timer 4
        m.hold = 1'b1;
        cfg(2'd2, 8'd10);
        m.hold = 1'b0;
        wait_phase("to_study3", 2'd2);
        for (int i = 0; i < 4; i++) tick();
        chk("shr_st4", 32'(m.status), 2);
        cfg(2'd2, 8'd2);
        chk("shr_st5", 32'(m.status), 2);
        tick();
        chk("shr_mtg", 32'(m.status), 3);
        chk("shr_ack", 32'(m.mtg_ack), 0);

        // reset during an ack pulse
        wait_phase("to_study4", 2'd2);
        m.mtg_req = 1'b1;
        tick();
        chk("ra_st", 32'(m.status), 3);
        chk("ra_ack", 32'(m.mtg_ack), 1);
        rst = 1'b1;
        m.mtg_req = 1'b0;
        tick();
        chk("rm_st", 32'(m.status), 0);
        chk("rm_home", 32'(m.home), 1);
        chk("rm_ack", 32'(m.mtg_ack), 0);
        chk("rm_day", 32'(m.day_cnt), 0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("rm_seq%0d", i), 32'(m.status), 32'(i % 4));
        end
        chk("rm_day1", 32'(m.day_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/day_scheduler.md
# day_scheduler

Programmable sequencer for the four-phase daily activity cycle (SLEEP → CLASS → STUDY → MEETING → SLEEP). Each phase holds for a configurable number of cycles. An external meeting requester can cut STUDY short through a req/ack handshake, and a hold input freezes the schedule. The block sits above the activity datapath: it drives the current phase code and the `home` flag, and counts completed days.

## Interface
Parameters:
- `CNT_W`, default 8: width of the per-phase dwell registers and the phase timer.
- `DAY_W`, default 8: width of the completed-day counter.

Ports:
- `clk`: input, 1 bit. Single clock; every flop is on the rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `hold`: input, 1 bit. Freezes phase, timer and day counter while high.
- `cfg_we`: input, 1 bit. Dwell register write strobe.
- `cfg_sel`: input, 2 bits. Phase whose dwell register is written.
- `cfg_data`: input, `CNT_W` bits. Dwell value in cycles.
- `mtg_req`: input, 1 bit. Meeting request (level).
- `mtg_ack`: output, 1 bit. One-cycle pulse that grants a meeting request.
- `status`: output, 2 bits. Current phase: SLEEP=00, CLASS=01, STUDY=10, MEETING=11.
- `home`: output, 1 bit. 1 in SLEEP, 0 otherwise.
- `day_cnt`: output, `DAY_W` bits. Number of completed days.

## Operation
- **Reset values:** `status`=SLEEP, `home`=1, `mtg_ack`=0, `day_cnt`=0, timer=0, all four dwell registers=1.
- **Dwell:** a phase lasts `dwell[phase]` cycles. A dwell value of 0 is treated as 1.
- **Timer:** starts at 0 on entry to a phase and increments each non-hold cycle. The phase ends when `timer >= eff_dwell-1`. Using `>=` lets a shrunk dwell end the phase immediately.
- **Phase end:** the next phase follows the fixed order. The timer clears to 0.
- **Day count:** the MEETING→SLEEP transition increments `day_cnt`, which wraps modulo 2^DAY_W.
- **Preemption:** if `mtg_req`=1 in any STUDY cycle, the next phase is MEETING regardless of the timer.
- **Acknowledge:** `mtg_ack` is 1 for exactly the first cycle of MEETING whenever `mtg_req` was 1 on the STUDY→MEETING transition edge (preempted or normal timeout). It is 0 otherwise.
  - `mtg_req` is ignored in SLEEP, CLASS and MEETING. It is not latched, so the requester must hold it until ack.
  - The requester deasserts `mtg_req` in the ack cycle. If it stays high, it has no further effect until the next STUDY.
- **Hold:** while `hold`=1, `status`, timer and `day_cnt` do not change and no preemption occurs. `mtg_ack` is forced 0 during hold. Config writes are still accepted.
- **Config write:** `cfg_we`=1 writes `cfg_data` into `dwell[cfg_sel]` at the edge.
  - A transition in the same cycle uses the old value.
  - A write to the current phase's dwell affects the end compare from the next cycle onward.
- **Priority within a cycle:** `rst` > `hold` > preemption > timer expiry.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- A phase change is visible one cycle after the end condition is sampled.
- With the default dwell of 1, `status` steps one phase per cycle: the first CLASS is in cycle 1 after reset release, and a full day takes 4 cycles.
- Preemption latency: `mtg_req` sampled high in STUDY cycle N gives MEETING and `mtg_ack`=1 in cycle N+1.
- `home` changes in the same cycle as `status` (entering and leaving SLEEP).
- Asserting `rst` mid-phase, mid-hold or during an ack pulse returns everything to the reset values at the next edge. Dwell configuration is lost.

## Structure
- **Package `sched_pkg`:**
  - 2-bit phase typedef with the four encodings.
  - `DWELL_RST` = 1.
  - A `next_phase()` function implementing the fixed order.
- **Sub-module `dwell_timer`:** `CNT_W`-bit counter with clear, enable and a `>= limit-1` terminal compare, including the 0→1 dwell substitution. It is instantiated once.
- **Top level:** holds the phase register, dwell register file, ack flop and day counter.

## Test plan
- **Reset and defaults:** release `rst` with `hold`=0 and `mtg_req`=0, run 8 cycles → `status` 00,01,10,11,00,01,10,11; `home` 1,0,0,0,1,…; `day_cnt`=1 after cycle 4 and 2 after cycle 8; `mtg_ack` never 1.
- **Programmed dwell:** write dwell = {3,2,5,1} → SLEEP lasts 3 cycles, CLASS 2, STUDY 5, MEETING 1; `day_cnt` increments every 11 cycles; writing 0 to a phase's dwell makes that phase last 1 cycle.
- **Preemption:** STUDY dwell=5, assert `mtg_req` in STUDY cycle 2 → MEETING on the next cycle, `mtg_ack`=1 for 1 cycle; `mtg_req` asserted during CLASS only → no effect, no ack.
- **Hold:** assert `hold` for 4 cycles mid-STUDY with `mtg_req`=1 → `status` and timer frozen, `mtg_ack`=0; on release, MEETING follows 1 cycle later with ack.
- **Dwell shrink and wrap:** in STUDY with timer=4, write STUDY dwell=2 → MEETING on the next edge. Separately, with `DAY_W`=2, run 4 days → `day_cnt` wraps 3→0.
- **Reset mid-operation:** assert `rst` during MEETING with an ack pulse active → next cycle `status`=00, `home`=1, `mtg_ack`=0, `day_cnt`=0, all dwell values back to 1.
